sdft_ctrl: RTL and testbench

SDFT_CTRL -- requirements
Module: sdft_ctrl

---
 rtl/sdft_ctrl.sv | 134 +++++++++++++
 tb/tb_sdft_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sdft_ctrl.sv
// Sliding-DFT control: accepts one sample, fetches x[n-g_N] from the external delay line,
// stores x[n], then issues all g_N bins with the shared difference. Macro SDFT_CTRL_ZERO_INIT_EN clears the delay line after reset.
module sdft_ctrl #(
  parameter int g_N      = 512,
  parameter int g_DATA_W = 12
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  output logic                     o_axisReady,
  input  logic [15:0]              i_axisData,
  input  logic                     i_axisValid,
  output logic [$clog2(g_N)-1:0]   o_delayAddr,
  output logic                     o_delayRdEn,
  output logic                     o_delayWrEn,
  output logic [g_DATA_W-1:0]      o_delayWrData,
  input  logic [g_DATA_W-1:0]      i_delayRdData,
  output logic signed [g_DATA_W:0] o_binDiff,
  output logic [$clog2(g_N)-1:0]   o_binAddr,
  output logic                     o_binValid,
  input  logic                     i_binReady,
  output logic                     o_binLast
);

  localparam int            AW       = $clog2(g_N);
  localparam logic [AW-1:0] LAST_IDX = AW'(g_N - 1);

`ifdef SDFT_CTRL_ZERO_INIT_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_DIFF, S_SWEEP} state_t;
  localparam state_t START_STATE = S_INIT;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_DIFF, S_SWEEP} state_t;
  localparam state_t START_STATE = S_IDLE;
`endif

  state_t                     state_q, state_d;
  logic                       run_q;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              k_q, k_d;
  logic [g_DATA_W-1:0]        sample_q, sample_d;
  logic signed [g_DATA_W:0]   diff_q, diff_d;

  // run_q holds every strobe low until the first edge after reset release,
  // so the start state can be entered without its outputs showing during reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= START_STATE;
      run_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assignment first; without it a missed branch would infer a latch.
    state_d = state_q;
    if (run_q) begin
      unique case (state_q)
`ifdef SDFT_CTRL_ZERO_INIT_EN
        S_INIT:  if (wr_ptr_q == LAST_IDX) state_d = S_IDLE;
`endif
        S_IDLE:  if (i_axisValid) state_d = S_READ;
        S_READ:  state_d = S_DIFF;
        S_DIFF:  state_d = S_SWEEP;
        S_SWEEP: if (i_binReady && k_q == LAST_IDX) state_d = S_IDLE;
        default: state_d = START_STATE;
      endcase
    end
  end

  always_comb begin
    o_axisReady   = 1'b0;
    o_delayRdEn   = 1'b0;
    o_delayWrEn   = 1'b0;
    o_delayWrData = '0;
    o_binValid    = 1'b0;
    if (run_q) begin
      unique case (state_q)
`ifdef SDFT_CTRL_ZERO_INIT_EN
        S_INIT:  o_delayWrEn = 1'b1;
`endif
        S_IDLE:  o_axisReady = 1'b1;
        S_READ:  o_delayRdEn = 1'b1;
        S_DIFF: begin
          o_delayWrEn   = 1'b1;
          o_delayWrData = sample_q;
        end
        S_SWEEP: o_binValid = 1'b1;
        default: ;
      endcase
    end
    o_delayAddr = wr_ptr_q;
    o_binAddr   = k_q;
    o_binLast   = o_binValid && (k_q == LAST_IDX);
    o_binDiff   = diff_q;
  end

  // Every delay-line write (zero-fill or sample store) advances the pointer; g_N is a power of two so it wraps for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    sample_d = sample_q;
    diff_d   = diff_q;
    if (o_axisReady && i_axisValid) sample_d = i_axisData[g_DATA_W-1:0];
    if (o_delayWrEn) wr_ptr_d = wr_ptr_q + AW'(1);
    if (state_q == S_DIFF)
      diff_d = {sample_q[g_DATA_W-1], sample_q} - {i_delayRdData[g_DATA_W-1], i_delayRdData};
    if (o_binValid && i_binReady) k_d = o_binLast ? '0 : k_q + AW'(1);
  end

  // NOTE: the delay-line RAM is external and deliberately not reset here; only control and output registers are.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      k_q      <= '0;
      sample_q <= '0;
      diff_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
      sample_q <= sample_d;
      diff_q   <= diff_d;
    end
  end

  generate
    if (g_DATA_W < 16) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^i_axisData[15:g_DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_sdft_ctrl.sv
// Self-checking bench for sdft_ctrl (g_N=8, 12-bit samples): delay-line RAM model plus a
// circular-buffer reference that predicts addresses, write data and bin differences.
module tb_sdft_ctrl;

  localparam int N  = 8;
  localparam int DW = 12;
  localparam int AW = 3;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 o_axisReady;
  logic [15:0]          i_axisData = '0;
  logic                 i_axisValid = 1'b0;
  logic [AW-1:0]        o_delayAddr;
  logic                 o_delayRdEn;
  logic                 o_delayWrEn;
  logic [DW-1:0]        o_delayWrData;
  logic [DW-1:0]        i_delayRdData;
  logic signed [DW:0]   o_binDiff;
  logic [AW-1:0]        o_binAddr;
  logic                 o_binValid;
  logic                 i_binReady = 1'b1;
  logic                 o_binLast;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] ram [N] = '{default: '0};
  int            ref_mem [N] = '{default: 0};
  int            ref_ptr = 0;
  logic [3:0]    stall_pat = 4'b1001;

  sdft_ctrl #(.g_N(N), .g_DATA_W(DW)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_axisReady   (o_axisReady),
    .i_axisData    (i_axisData),
    .i_axisValid   (i_axisValid),
    .o_delayAddr   (o_delayAddr),
    .o_delayRdEn   (o_delayRdEn),
    .o_delayWrEn   (o_delayWrEn),
    .o_delayWrData (o_delayWrData),
    .i_delayRdData (i_delayRdData),
    .o_binDiff     (o_binDiff),
    .o_binAddr     (o_binAddr),
    .o_binValid    (o_binValid),
    .i_binReady    (i_binReady),
    .o_binLast     (o_binLast)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous RAM with one-cycle read latency; under the zero-init build it is scrambled while in reset.
  always @(posedge i_clk) begin
`ifdef SDFT_CTRL_ZERO_INIT_EN
    if (!i_reset) for (int i = 0; i < N; i++) ram[i] <= DW'(i * 37 + 5);
`endif
    if (o_delayWrEn) ram[o_delayAddr] <= o_delayWrData;
    if (o_delayRdEn) i_delayRdData <= ram[o_delayAddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", {o_axisReady, o_delayRdEn, o_delayWrEn, o_binValid, o_binLast, o_delayAddr, o_binAddr}, 0);
    check("rst_dat", {o_delayWrData, o_binDiff}, 0);
  endtask

  // Called on a falling edge with reset asserted; returns on a falling edge with the block ready.
  task automatic release_reset();
    ref_ptr = 0;
    i_reset = 1'b1;
    #1 check("rel_ready", o_axisReady, 0);
`ifdef SDFT_CTRL_ZERO_INIT_EN
    for (int i = 0; i < N; i++) begin
      @(negedge i_clk);
      check("init_wr", o_delayWrEn, 1);
      check("init_addr", o_delayAddr, i);
      check("init_data", o_delayWrData, 0);
      check("init_rdy", o_axisReady, 0);
      ref_mem[i] = 0;
    end
`endif
    @(negedge i_clk);
    check("idle_ready", o_axisReady, 1);
    check("idle_strb", {o_delayWrEn, o_delayRdEn, o_binValid}, 0);
  endtask

  task automatic idle(input int n);
    i_axisValid = 1'b0;
    repeat (n) @(negedge i_clk);
    check("idle_hold", o_axisReady, 1);
  endtask

  // mode 0: ready always high, 1: 1,0,0,1 pattern, 2: random. abort_k >= 0 resets the block at that bin.
  task automatic run_sample(input logic [15:0] data, input int mode, input int abort_k);
    int  s, exp_diff, k, cyc;
    logic rdy;
    bit  got;
    s = int'($signed(data[DW-1:0]));
    i_axisData  = data;
    i_axisValid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (o_axisReady) begin
        got = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    check("accept_wait", got, 1);
    if (!got) return;

    @(negedge i_clk);
    i_axisData = 16'($urandom);
    exp_diff = s - ref_mem[ref_ptr];
    check("rd_strb", {o_delayRdEn, o_delayWrEn, o_axisReady, o_binValid}, 4'b1000);
    check("rd_addr", o_delayAddr, ref_ptr);

    @(negedge i_clk);
    check("wr_strb", {o_delayRdEn, o_delayWrEn, o_axisReady, o_binValid}, 4'b0100);
    check("wr_addr", o_delayAddr, ref_ptr);
    check("wr_data", o_delayWrData, data[DW-1:0]);
    ref_mem[ref_ptr] = s;
    ref_ptr = (ref_ptr + 1) % N;

    @(negedge i_clk);
    k = 0;
    cyc = 0;
    while (k < N && cyc < 100) begin
      check("bin_valid", o_binValid, 1);
      check("bin_addr", o_binAddr, k);
      check("bin_last", o_binLast, (k == N - 1));
      check("bin_diff", o_binDiff, exp_diff);
      check("sweep_strb", {o_axisReady, o_delayRdEn, o_delayWrEn}, 0);
      if (k == abort_k) begin
        i_reset = 1'b0;
        #1 check_reset_outputs();
`ifdef SDFT_CTRL_ZERO_INIT_EN
        for (int i = 0; i < N; i++) ref_mem[i] = 0;
`endif
        @(negedge i_clk);
        release_reset();
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = stall_pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_binReady = rdy;
      @(negedge i_clk);
      if (rdy) k++;
      cyc++;
    end
    check("sweep_done", k, N);
    check("post_ready", o_axisReady, 1);
    check("post_valid", o_binValid, 0);
    i_binReady = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check_reset_outputs();
    release_reset();

    for (int i = 1; i <= 9; i++) run_sample({4'($urandom), 12'(i)}, 0, -1);
    idle(3);
    run_sample(16'h07FF, 0, -1);
    for (int i = 0; i < 7; i++) run_sample(16'($urandom), $urandom_range(0, 2), -1);
    run_sample(16'hA800, 1, -1);
    for (int i = 0; i < 12; i++) run_sample(16'($urandom), $urandom_range(0, 2), -1);
    idle(2);
    run_sample(16'($urandom), 0, 4);
    for (int i = 0; i < 10; i++) run_sample(16'($urandom), $urandom_range(0, 2), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
